// File: rtl/poisson_spike_encoder.sv
// rtl/poisson_spike_encoder.sv - rate-codes a stored pixel frame into a stream of spike bits
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   pix_we_i/pix_waddr_i/pix_wdata_i  pixel RAM write port (accepted in IDLE only)
//   start_i, seed_i               begin a run with the given LFSR seed (IDLE only)
//   rand_i                        current sample from the external random LFSR
//   rand_seed_o, rand_set_seed_o  seed value and one-cycle load strobe to that LFSR
//   spk_valid_o/spk_ready_i       beat handshake
//   spk_o, spk_addr_o, spk_ts_o, spk_last_o  beat payload
//   busy_o                        run in progress (SEED/RUN/DRAIN)
//   done_o                        one-cycle pulse when the run has fully drained
module poisson_spike_encoder #(
    parameter int NUM_INPUTS = 64,
    parameter int TIMESTEPS  = 16,
    parameter int ADDR_W     = $clog2(NUM_INPUTS),
    parameter int TS_W       = (TIMESTEPS > 1) ? $clog2(TIMESTEPS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_we_i,
    input  logic [ADDR_W-1:0] pix_waddr_i,
    input  logic [7:0]        pix_wdata_i,
    input  logic              start_i,
    input  logic [7:0]        seed_i,
    input  logic [7:0]        rand_i,
    output logic [7:0]        rand_seed_o,
    output logic              rand_set_seed_o,
    output logic              spk_valid_o,
    input  logic              spk_ready_i,
    output logic              spk_o,
    output logic [ADDR_W-1:0] spk_addr_o,
    output logic [TS_W-1:0]   spk_ts_o,
    output logic              spk_last_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_INPUTS - 1);
    localparam logic [TS_W-1:0]   LAST_TS   = TS_W'(TIMESTEPS - 1);

    state_t            state_q;
    state_t            state_d;
    logic [7:0]        pix_mem [NUM_INPUTS];
    logic [ADDR_W-1:0] addr_q;
    logic [TS_W-1:0]   ts_q;
    logic              load;
    logic              last_beat;

    // Output register takes a new beat when empty or when the held one is accepted.
    assign load      = !spk_valid_o || spk_ready_i;
    assign last_beat = (addr_q == LAST_ADDR) && (ts_q == LAST_TS);

    always_comb begin
        state_d         = state_q;
        rand_set_seed_o = 1'b0;
        busy_o          = 1'b0;
        done_o          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_SEED;
            end
            S_SEED: begin
                rand_set_seed_o = 1'b1;
                busy_o          = 1'b1;
                state_d         = S_RUN;
            end
            S_RUN: begin
                busy_o = 1'b1;
                if (load && last_beat) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                busy_o = 1'b1;
                if (spk_ready_i) state_d = S_DONE;
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pixel RAM: writes land in IDLE only, including the cycle start_i is seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_INPUTS; i++) pix_mem[i] <= 8'd0;
        end else if (state_q == S_IDLE && pix_we_i && (int'(pix_waddr_i) < NUM_INPUTS)) begin
            pix_mem[pix_waddr_i] <= pix_wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rand_seed_o <= 8'd0;
            addr_q      <= '0;
            ts_q        <= '0;
            spk_valid_o <= 1'b0;
            spk_o       <= 1'b0;
            spk_addr_o  <= '0;
            spk_ts_o    <= '0;
            spk_last_o  <= 1'b0;
        end else begin
            state_q <= state_d;

            if (state_q == S_IDLE && start_i) begin
                rand_seed_o <= seed_i;
                addr_q      <= '0;
                ts_q        <= '0;
            end

            // rand_i free-runs; it is only consumed on the edge a beat is loaded.
            if (state_q == S_RUN && load) begin
                spk_valid_o <= 1'b1;
                spk_o       <= (pix_mem[addr_q] > rand_i);
                spk_addr_o  <= addr_q;
                spk_ts_o    <= ts_q;
                spk_last_o  <= last_beat;
                if (addr_q == LAST_ADDR) begin
                    addr_q <= '0;
                    ts_q   <= (ts_q == LAST_TS) ? '0 : ts_q + 1'b1;
                end else begin
                    addr_q <= addr_q + 1'b1;
                end
            end

            if (state_q == S_DRAIN && spk_ready_i) begin
                spk_valid_o <= 1'b0;
                spk_o       <= 1'b0;
                spk_addr_o  <= '0;
                spk_ts_o    <= '0;
                spk_last_o  <= 1'b0;
            end
        end
    end

endmodule
